// File: rtl/bram_port_sequencer_if.sv
// Request, response and raw BRAM strobe bundle for one BRAM port sequencer.
// The master side is the requester plus the BRAM; the slave side is the sequencer.
interface bram_port_sequencer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport master (
        output req_valid, req_we, req_addr, req_data, rsp_ready, bram_dout,
        input  req_ready, rsp_valid, rsp_data, bram_en, bram_we, bram_addr, bram_din
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data, rsp_ready, bram_dout,
        output req_ready, rsp_valid, rsp_data, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/bram_port_sequencer.sv
// Valid/ready front-end for one write-first BRAM port with latency tracking and a credit-guarded response FIFO.
// Define BRAM_SEQ_WRITE_ACK_EN to make writes return their write-first DO as an ordered response too.
module bram_port_sequencer #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    bram_port_sequencer_if.slave   bus
);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(RESP_DEPTH);

    logic [READ_LATENCY-1:0] r_pipe;
    logic [READ_LATENCY-1:0] w_pipe_next;
    logic [DATA_WIDTH-1:0]   r_mem [RESP_DEPTH];
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_next;
    logic [CNT_W:0]          w_occupancy;

    logic                    w_fire;
    logic                    w_track;
    logic                    w_credit_ok;
    logic                    w_push;
    logic                    w_pop;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_din;

    // Occupancy counts buffered responses plus reads still travelling through the BRAM.
    always_comb begin
        w_occupancy = {1'b0, r_count};
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_occupancy = w_occupancy + {{CNT_W{1'b0}}, r_pipe[i]};
        end
    end

    assign w_credit_ok = (w_occupancy < {1'b0, LP_DEPTH});

`ifdef BRAM_SEQ_WRITE_ACK_EN
    assign bus.req_ready = !RST && w_credit_ok;
    assign w_track       = w_fire;
`else
    assign bus.req_ready = !RST && (bus.req_we || w_credit_ok);
    assign w_track       = w_fire && !bus.req_we;
`endif

    assign w_fire        = bus.req_valid && bus.req_ready;
    assign w_addr        = bus.req_addr;
    assign w_din         = bus.req_data;
    assign bus.bram_en   = w_fire;
    assign bus.bram_we   = bus.req_we;
    assign bus.bram_addr = w_addr;
    assign bus.bram_din  = w_din;

    assign w_pipe_next[0] = w_track;
    generate
        for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
            assign w_pipe_next[gi] = r_pipe[gi-1];
        end
    endgenerate

    // The last pipe stage marks the edge at which DO carries the tracked result.
    assign w_push = r_pipe[READ_LATENCY-1];
    assign w_pop  = (r_count != '0) && bus.rsp_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pipe   <= '0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_pipe  <= w_pipe_next;
            r_count <= w_count_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.bram_dout;
    end

    assign bus.rsp_valid = (r_count != '0);
    assign bus.rsp_data  = r_mem[r_rd_ptr];

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(w_push && !w_pop && (r_count == LP_DEPTH)));

endmodule

// File: tb/tb_bram_port_sequencer.sv
// Directed and randomized bench for bram_port_sequencer: L=2 instance against a queue-based model,
// plus an L=1 instance for the latency check.
module tb_bram_port_sequencer;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic CLK;
    logic RST;

    bram_port_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    bram_port_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    bram_port_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .RESP_DEPTH(DEPTH))
        u_dut (.CLK(CLK), .RST(RST), .bus(bus));

    bram_port_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RESP_DEPTH(DEPTH))
        u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Write-first BRAM models: one with an extra output register, one without.
    logic [DW-1:0] b0_mem [1024];
    logic [DW-1:0] b0_d1, b0_d2;
    logic [DW-1:0] b1_mem [1024];
    logic [DW-1:0] b1_d1;

    always @(posedge CLK) begin
        if (bus.bram_en) begin
            if (bus.bram_we) begin
                b0_mem[bus.bram_addr] <= bus.bram_din;
                b0_d1 <= bus.bram_din;
            end else begin
                b0_d1 <= b0_mem[bus.bram_addr];
            end
        end
        b0_d2 <= b0_d1;
        if (bus1.bram_en) begin
            if (bus1.bram_we) begin
                b1_mem[bus1.bram_addr] <= bus1.bram_din;
                b1_d1 <= bus1.bram_din;
            end else begin
                b1_d1 <= b1_mem[bus1.bram_addr];
            end
        end
    end
    assign bus.bram_dout  = b0_d2;
    assign bus1.bram_dout = b1_d1;

    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] shadow [1024];
    int            cyc;
    int            n_tests;
    int            n_fail;
    int            n_pops;
    int            n_fires;
    bit            last_fire;
    bit            last_pop;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the L=2 instance: check outputs at the falling edge, then advance the model.
    task automatic step();
        bit            exp_ready, exp_fire, exp_rv, rst_s, c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_data;
        @(negedge CLK);
        if (RST) exp_ready = 1'b0;
`ifdef BRAM_SEQ_WRITE_ACK_EN
        else exp_ready = (q.size() < DEPTH);
`else
        else exp_ready = bus.req_we || (q.size() < DEPTH);
`endif
        check("req_ready", bus.req_ready, exp_ready);
        exp_fire = bus.req_valid && exp_ready;
        check("bram_en", bus.bram_en, exp_fire);
        if (exp_fire) begin
            check("bram_we", bus.bram_we, bus.req_we);
            check("bram_addr", bus.bram_addr, bus.req_addr);
            check("bram_din", bus.bram_din, bus.req_data);
        end
        exp_rv = (q.size() > 0) && (q[0].avail <= cyc);
        check("rsp_valid", bus.rsp_valid, exp_rv);
        if (exp_rv) check("rsp_data", bus.rsp_data, q[0].data);
        c_we = bus.req_we; c_addr = bus.req_addr; c_data = bus.req_data;
        last_fire = exp_fire;
        last_pop  = exp_rv && bus.rsp_ready;
        rst_s     = RST;
        @(posedge CLK);
        cyc++;
        if (rst_s) begin
            q.delete();
        end else begin
            if (last_pop) begin
                void'(q.pop_front());
                n_pops++;
            end
            if (last_fire) begin
                n_fires++;
                if (c_we) begin
                    shadow[c_addr] = c_data;
`ifdef BRAM_SEQ_WRITE_ACK_EN
                    q.push_back('{data: c_data, avail: cyc + LAT});
`endif
                end else begin
                    q.push_back('{data: shadow[c_addr], avail: cyc + LAT});
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_data  = d;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int idx, p0, f0, win;
        n_tests = 0; n_fail = 0; n_pops = 0; n_fires = 0; cyc = 0;
        RST = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        bus.rsp_ready  = 1'b1;
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_data = '0;
        bus1.rsp_ready = 1'b1;
        @(posedge CLK); #1;

        // Reset with requests pending: nothing may be accepted or issued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom_range(1)), AW'($urandom_range(7)), $urandom);
            step();
            check("rst_ready1", bus1.req_ready, 1'b0);
            check("rst_en1", bus1.bram_en, 1'b0);
            check("rst_rsp_valid1", bus1.rsp_valid, 1'b0);
        end
        RST = 1'b0;
        bus1.req_valid = 1'b0;
        idle(1);

        // L=1 instance: preload 5, read it back, check the exact response cycle.
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 10'd5; bus1.req_data = 32'hDEADBEEF;
        @(negedge CLK);
        check("l1_wr_ready", bus1.req_ready, 1'b1);
        @(posedge CLK); #1;
        bus1.req_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0;
        @(negedge CLK);
        check("l1_rd_ready", bus1.req_ready, 1'b1);
        @(posedge CLK); #1;
        bus1.req_valid = 1'b0;
        @(negedge CLK);
        check("l1_rv_e0", bus1.rsp_valid, 1'b0);
        @(negedge CLK);
        check("l1_rv_e1", bus1.rsp_valid, 1'b1);
        check("l1_data_e1", bus1.rsp_data, 32'hDEADBEEF);
        @(negedge CLK);
        check("l1_rv_e2", bus1.rsp_valid, 1'b0);
        @(posedge CLK); #1;

        // L=2 instance: preload 5 and read it (timing checked by the model).
        drive(1'b1, 1'b1, 10'd5, 32'hDEADBEEF); step();
        idle(4);
        drive(1'b1, 1'b0, 10'd5, '0); step();
        idle(5);

        // Seed addresses 0..7 with their own index.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'(i)); step();
        end
        idle(6);

        // Back-pressure: only DEPTH reads may be admitted while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        idx = 0; p0 = n_pops;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, AW'(idx), '0); step();
            if (last_fire) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd4);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60 && !(idx == 8 && q.size() == 0); i++) begin
            if (idx < 8) drive(1'b1, 1'b0, AW'(idx), '0);
            else         drive(1'b0, 1'b0, '0, '0);
            step();
            if (last_fire && idx < 8) idx++;
        end
        check("bp_all_accepted", 32'(idx), 32'd8);
        check("bp_all_returned", 32'(n_pops - p0), 32'd8);

        // Throughput: 16 back-to-back reads, one response per cycle.
        idle(2);
        p0 = n_pops; win = 0;
        for (int i = 0; i < 16 + LAT + 1; i++) begin
            if (i < 16) drive(1'b1, 1'b0, AW'(i % 8), '0);
            else        drive(1'b0, 1'b0, '0, '0);
            step();
            if (i < 16) check("tput_accept", last_fire, 1'b1);
            if (i > LAT && last_pop) win++;
        end
        check("tput_consecutive", 32'(win), 32'd16);
        check("tput_total", 32'(n_pops - p0), 32'd16);

        // Read-after-write on consecutive cycles.
        idle(2);
        p0 = n_pops;
        drive(1'b1, 1'b1, 10'd3, 32'h12345678); step();
        drive(1'b1, 1'b0, 10'd3, '0); step();
        idle(6);
`ifdef BRAM_SEQ_WRITE_ACK_EN
        check("raw_responses", 32'(n_pops - p0), 32'd2);
`else
        check("raw_responses", 32'(n_pops - p0), 32'd1);
`endif

        // Randomized traffic against the model.
        f0 = n_fires;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), ($urandom_range(2) == 0), AW'($urandom_range(7)), $urandom);
            bus.rsp_ready = ($urandom_range(3) != 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        idle(8);
        check("rand_drained", 32'(q.size()), 32'd0);
        check("rand_progress", 32'(n_fires - f0 > 100), 32'd1);

        // Reset with two reads in the pipe and one in the FIFO.
        bus.rsp_ready = 1'b0;
        f0 = n_fires;
        drive(1'b1, 1'b0, 10'd1, '0); step();
        drive(1'b1, 1'b0, 10'd2, '0); step();
        drive(1'b1, 1'b0, 10'd3, '0); step();
        check("mid_accepted", 32'(n_fires - f0), 32'd3);
        check("mid_fifo_valid", bus.rsp_valid, 1'b1);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        bus.rsp_ready = 1'b1;
        check("mid_rv_after_rst", bus.rsp_valid, 1'b0);
        idle(6);
        check("mid_no_stale", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_port_sequencer.md
Name: bram_port_sequencer

Overview:
- Upstream front-end for one port of the dual-ported write-first BRAM.
- Converts a valid/ready request stream (read or write) into the BRAM's raw EN/WE/ADDR/DI strobes.
- Tracks the BRAM's fixed read latency (1, or 2 when the BRAM is built PIPELINED) and captures DO at exactly the right cycle into a response FIFO with valid/ready output.
- Credit-based admission guarantees no response is ever dropped, so the requester sees a clean, back-pressurable memory.

Parameters:
- ADDR_WIDTH, 10, address width; matches the BRAM's ADDR_WIDTH.
- DATA_WIDTH, 32, data width; matches the BRAM's DATA_WIDTH.
- READ_LATENCY, 1, BRAM read latency in cycles. Legal values are 1 (non-pipelined BRAM) or 2 (PIPELINED BRAM).
- RESP_DEPTH, 4, response FIFO entries. Power of 2, at least READ_LATENCY+2 for full throughput.

Ports:
- CLK  in  1  clock, shared with the BRAM port.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_WIDTH  read data (head of response FIFO).
- bram_en  out  1  to BRAM EN.
- bram_we  out  1  to BRAM WE.
- bram_addr  out  ADDR_WIDTH  to BRAM ADDR.
- bram_din  out  DATA_WIDTH  to BRAM DI.
- bram_dout  in  DATA_WIDTH  from BRAM DO.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.

Reset:
- While RST is high: req_ready=0, bram_en=0.
- After the RST edge: rsp_valid=0; FIFO count, read pointer and write pointer = 0; in-flight pipe = 0.
- Reset mid-operation discards all in-flight and buffered reads. BRAM contents are untouched.
- After RST deasserts: req_ready=1 in the first cycle.

Issue:
- fire = req_valid && req_ready.
- bram_en = fire. bram_we = req_we. bram_addr = req_addr. bram_din = req_data. All combinational.
- No other path drives bram_en.

Credits:
- inflight = popcount(pipe).
- A read is admissible iff count + inflight < RESP_DEPTH, using registered values only.
- There is no combinational path from rsp_ready to req_ready.
- Writes generate no response (macro off) and are always admissible: req_ready = !RST && (req_we || credit_ok).

Latency pipe:
- pipe is a READ_LATENCY-bit shift register, advancing every cycle.
- pipe[0] <= fire && !req_we.
- When pipe[READ_LATENCY-1]=1, bram_dout is sampled into the FIFO tail at that edge, i.e. READ_LATENCY edges after the accept edge.
- Result: a read accepted at edge E0 shows rsp_valid=1 in the cycle after edge E(READ_LATENCY).

FIFO:
- rsp_valid = (count != 0). rsp_data = mem[rd_ptr].
- Pop on rsp_valid && rsp_ready.
- Push and pop in the same cycle leaves count unchanged; both pointers advance and wrap modulo RESP_DEPTH.
- Push while full cannot occur (credit invariant). An assertion flags it in simulation.

Ordering:
- Responses return in request order.
- Read-after-write to the same address on consecutive cycles returns the new data, because the BRAM port serialises.
- Write-first: a write's DO is ignored.

Throughput:
- One request per cycle sustained when rsp_ready is held high and RESP_DEPTH ≥ READ_LATENCY+2.

Optional Feature:
- Macro: BRAM_SEQ_WRITE_ACK_EN.
- Defined:
  - Writes also consume a credit and set pipe[0].
  - Their response is the write-first DO, i.e. the written data, so every request yields exactly one ordered response.
  - req_ready = !RST && credit_ok for all requests.
- Undefined: writes produce no response, as described in Behaviour.

Test Plan:
- Reset/idle: RST high 3 cycles then low.
  - During RST: req_ready=0, bram_en=0 every cycle.
  - After the RST edge: rsp_valid=0.
  - First cycle after RST deasserts: req_ready=1.
- Latency, READ_LATENCY=1 and 2:
  - Preload addr 5=0xDEADBEEF, read addr 5 with rsp_ready=1.
  - rsp_data=0xDEADBEEF with rsp_valid in the cycle after edge E1 (L=1) or E2 (L=2), for exactly 1 cycle.
- Back-pressure:
  - rsp_ready=0, stream reads to addrs 0..7 (RESP_DEPTH=4).
  - Exactly 4 accepted, then req_ready=0.
  - Raise rsp_ready: data 0..3 in order, then remaining reads resume with no loss or duplication.
- Throughput:
  - L=2, depth 4, rsp_ready=1, 16 back-to-back reads.
  - req_ready stays 1 throughout; 16 responses on consecutive cycles.
- RAW and writes:
  - Write addr 3=0x12345678, then read addr 3 next cycle.
  - Read returns 0x12345678. Macro off: the write yields no response.
  - Macro on: two responses, both 0x12345678, in order.
- Reset mid-flight:
  - Assert RST while 2 reads are in the pipe and 1 is in the FIFO.
  - Next cycle rsp_valid=0; no stale responses appear afterwards.
